// File: rtl/exhaust_key_if.sv
// Button/key bundle between the hood controller and the key front end.
// The master drives raw buttons and the power state; the slave returns debounced keys and pulses.
interface exhaust_key_if;
    logic [3:0] btn_raw;
    logic       is_on;
    logic       menu_key;
    logic       level1_key;
    logic       level2_key;
    logic       level3_key;
    logic [3:0] key_stable;
    logic       long_menu;

    modport master (
        output btn_raw,
        output is_on,
        input  menu_key,
        input  level1_key,
        input  level2_key,
        input  level3_key,
        input  key_stable,
        input  long_menu
    );

    modport slave (
        input  btn_raw,
        input  is_on,
        output menu_key,
        output level1_key,
        output level2_key,
        output level3_key,
        output key_stable,
        output long_menu
    );
endinterface

// File: rtl/exhaust_key_frontend.sv
// Range hood key front end: synchronise, debounce, rate-limit and prioritise four buttons.
// Define EXHAUST_KEY_LONGPRESS_EN to add the long-press detector on the menu key.
module exhaust_key_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLDOFF_CYCLES  = 4,
    parameter int LONG_CYCLES     = 200000000
) (
    input  logic          clk,
    input  logic          rst,
    exhaust_key_if.slave  kif
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575 ||
        HOLDOFF_CYCLES < 0 || HOLDOFF_CYCLES > 255 ||
        LONG_CYCLES < 1 || LONG_CYCLES > 268435455) begin : g_bad_param
        $error("exhaust_key_frontend: parameter out of range");
    end

    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HO_LOAD = 8'(HOLDOFF_CYCLES);

    typedef enum logic {
        READY   = 1'b0,
        HOLDOFF = 1'b1
    } emit_state_t;

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       stable_p2;
    logic [3:0]       stable_d_p3;
    logic [3:0][19:0] db_cnt;
    logic [3:0]       press;

    emit_state_t state;
    emit_state_t state_nxt;
    logic [7:0]  ho_cnt;
    logic [7:0]  ho_cnt_nxt;
    logic [3:0]  pulse;
    logic [3:0]  pulse_nxt;

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= kif.btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-key debounce; a level is accepted after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_p2 <= '0;
            db_cnt    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] != stable_p2[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable_p2[i] <= sync_p1[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 20'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Stage p3: delayed copy for rising-edge (press) detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d_p3 <= '0;
        end else begin
            stable_d_p3 <= stable_p2;
        end
    end

    assign press = stable_p2 & ~stable_d_p3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= READY;
            ho_cnt <= '0;
            pulse  <= '0;
        end else begin
            state  <= state_nxt;
            ho_cnt <= ho_cnt_nxt;
            pulse  <= pulse_nxt;
        end
    end

    // Presses seen outside READY or while powered off are dropped, never deferred
    always_comb begin
        state_nxt  = state;
        ho_cnt_nxt = ho_cnt;
        pulse_nxt  = '0;
        case (state)
            READY: begin
                if (kif.is_on && (press != 4'b0000)) begin
                    if (press[0]) begin
                        pulse_nxt = 4'b0001;
                    end else if (press[3]) begin
                        pulse_nxt = 4'b1000;
                    end else if (press[2]) begin
                        pulse_nxt = 4'b0100;
                    end else begin
                        pulse_nxt = 4'b0010;
                    end
                    if (HO_LOAD != 8'd0) begin
                        state_nxt  = HOLDOFF;
                        ho_cnt_nxt = HO_LOAD;
                    end
                end
            end
            HOLDOFF: begin
                if (ho_cnt <= 8'd1) begin
                    ho_cnt_nxt = '0;
                    state_nxt  = READY;
                end else begin
                    ho_cnt_nxt = ho_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt  = READY;
                ho_cnt_nxt = '0;
            end
        endcase
    end

    assign kif.menu_key   = pulse[0];
    assign kif.level1_key = pulse[1];
    assign kif.level2_key = pulse[2];
    assign kif.level3_key = pulse[3];
    assign kif.key_stable = stable_p2;

`ifdef EXHAUST_KEY_LONGPRESS_EN
    localparam logic [27:0] LONG_MAX  = 28'(LONG_CYCLES);
    localparam logic [27:0] LONG_LAST = 28'(LONG_CYCLES - 1);

    logic [27:0] long_cnt;
    logic        long_pulse;

    function automatic logic [27:0] sat_inc(input logic [27:0] v, input logic [27:0] lim);
        return (v >= lim) ? lim : v + 28'd1;
    endfunction

    // The pulse fires on the edge the counter reaches LONG_CYCLES; saturation prevents a repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (stable_p2[0]) begin
                long_cnt   <= sat_inc(long_cnt, LONG_MAX);
                long_pulse <= kif.is_on && (long_cnt == LONG_LAST);
            end else begin
                long_cnt <= '0;
            end
        end
    end

    assign kif.long_menu = long_pulse;
`else
    assign kif.long_menu = 1'b0;
`endif

endmodule
